// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver. A shadow digit store is copied to the
// display store at a frame boundary. One anode is scanned at a time with active-low pins.
module sevenseg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [3:0]            wr_data,
  input  logic                  commit,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  lz_en,
  output logic                  seg_a,
  output logic                  seg_b,
  output logic                  seg_c,
  output logic                  seg_d,
  output logic                  seg_e,
  output logic                  seg_f,
  output logic                  seg_g,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_start,
  output logic                  commit_pend
);

  localparam int DIV_W = $clog2(REFRESH_DIV);

  logic [DIV_W-1:0]      div;
  logic [IDX_W-1:0]      ptr;
  logic [3:0]            shadow  [NUM_DIGITS];
  logic [3:0]            display [NUM_DIGITS];
  logic                  tick;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] sup;
  logic                  all_zero;
  logic [3:0]            cur_val;
  logic                  cur_dark;
  logic [6:0]            seg_r;

  assign tick     = (div == DIV_W'(REFRESH_DIV - 1));
  assign boundary = tick && (ptr == IDX_W'(NUM_DIGITS - 1));

  // Walk from the leftmost digit down; a digit is suppressed while everything
  // at or above it is zero. Digit 0 is always shown.
  always_comb begin
    all_zero = 1'b1;
    sup      = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (display[i] == 4'h0);
      sup[i]   = lz_en && all_zero && (i != 0);
    end
  end

  assign cur_val  = display[ptr];
  assign cur_dark = blank_mask[ptr] || sup[ptr];

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0:    decode = 7'b0000001;
      4'h1:    decode = 7'b1001111;
      4'h2:    decode = 7'b0010010;
      4'h3:    decode = 7'b0000110;
      4'h4:    decode = 7'b1001100;
      4'h5:    decode = 7'b0100100;
      4'h6:    decode = 7'b0100000;
      4'h7:    decode = 7'b0001111;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0000100;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b1100000;
      4'hC:    decode = 7'b0110001;
      4'hD:    decode = 7'b1000010;
      4'hE:    decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      ptr         <= '0;
      frame_start <= 1'b0;
      commit_pend <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i]  <= 4'h0;
        display[i] <= 4'h0;
      end
    end else begin
      div         <= tick ? '0 : div + 1'b1;
      frame_start <= boundary;
      if (tick)
        ptr <= (ptr == IDX_W'(NUM_DIGITS - 1)) ? '0 : ptr + 1'b1;
      if (wr_en && (int'(wr_idx) < NUM_DIGITS))
        shadow[wr_idx] <= wr_data;
      // The copy takes the pre-edge shadow, so a write in the same cycle waits for the next commit.
      if (boundary && (commit_pend || commit)) begin
        display     <= shadow;
        commit_pend <= 1'b0;
      end else if (commit) begin
        commit_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an    <= '1;
      seg_r <= '1;
      dp    <= 1'b1;
    end else if (cur_dark) begin
      an    <= '1;
      seg_r <= '1;
      dp    <= 1'b1;
    end else begin
      an    <= ~(NUM_DIGITS'(1) << ptr);
      seg_r <= decode(cur_val);
      dp    <= ~dp_mask[ptr];
    end
  end

  assign seg_a = seg_r[6];
  assign seg_b = seg_r[5];
  assign seg_c = seg_r[4];
  assign seg_d = seg_r[3];
  assign seg_e = seg_r[2];
  assign seg_f = seg_r[1];
  assign seg_g = seg_r[0];

endmodule
